// File: rtl/iobus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iobus_pkg
//  Description : Shared types and I/O address map for the OTTER I/O bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package iobus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [31:0] ADDR_SWITCHES = 32'h1100_8000;
    localparam logic [31:0] ADDR_BUTTONS  = 32'h1100_8004;
    localparam logic [31:0] ADDR_LEDS     = 32'h1100_C000;
    localparam logic [31:0] ADDR_COUNT    = 32'h1100_C00C;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin choice; the pointer lives
//                in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_valid,
    output logic o_sel
);

    assign o_valid = i_req0 | i_req1;
    // On a tie the port that did not go last wins.
    assign o_sel   = (i_req0 & i_req1) ? ~i_last : i_req1;

endmodule
`default_nettype wire

// File: rtl/iobus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : iobus_arbiter
//  Description : Round-robin arbiter sharing the OTTER I/O bus between two
//                requesters, with per-access ack and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module iobus_arbiter
    import iobus_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_wr,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_wr,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] iobus_addr,
    output logic [31:0] iobus_out,
    output logic        iobus_wr,
    output logic        iobus_rd,
    input  logic [31:0] iobus_in,
    input  logic        iobus_ack,
    output logic        busy
);

    localparam int                 c_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last;
    logic                r_owner;
    logic                r_wr_lat;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_strb_wr;
    logic                r_strb_rd;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_done0;
    logic                r_done1;
    logic [31:0]         r_rdata0;
    logic [31:0]         r_rdata1;
    logic                r_err0;
    logic                r_err1;

    logic                w_pick_valid;
    logic                w_pick_sel;
    logic                w_finish;
    logic [31:0]         w_resp_data;

    rr_pick2 u_pick (
        .i_req0  (m0_req),
        .i_req1  (m1_req),
        .i_last  (r_last),
        .o_valid (w_pick_valid),
        .o_sel   (w_pick_sel)
    );

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_finish     = 1'b0;
        w_resp_data  = 32'h0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                // Ack takes precedence over a simultaneous timeout.
                w_finish = iobus_ack || (r_cnt == c_CNT_LAST);
                if (!r_wr_lat) begin
                    w_resp_data = iobus_ack ? iobus_in : ERR_DATA;
                end
                if (w_finish) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_wr_lat  <= 1'b0;
            r_cnt     <= '0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_strb_wr <= 1'b0;
            r_strb_rd <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_rdata0  <= 32'h0;
            r_rdata1  <= 32'h0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_valid) begin
                        r_owner   <= w_pick_sel;
                        r_addr    <= w_pick_sel ? m1_addr  : m0_addr;
                        r_wdata   <= w_pick_sel ? m1_wdata : m0_wdata;
                        r_wr_lat  <= w_pick_sel ? m1_wr    : m0_wr;
                        r_strb_wr <= w_pick_sel ? m1_wr    : m0_wr;
                        r_strb_rd <= w_pick_sel ? ~m1_wr   : ~m0_wr;
                        r_gnt0    <= ~w_pick_sel;
                        r_gnt1    <= w_pick_sel;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_finish) begin
                        r_strb_wr <= 1'b0;
                        r_strb_rd <= 1'b0;
                        if (r_owner) begin
                            r_done1  <= 1'b1;
                            r_rdata1 <= w_resp_data;
                            r_err1   <= ~iobus_ack;
                        end else begin
                            r_done0  <= 1'b1;
                            r_rdata0 <= w_resp_data;
                            r_err0   <= ~iobus_ack;
                        end
                    end
                end
                RESP: begin
                    r_cnt  <= '0;
                    r_last <= r_owner;
                    r_gnt0 <= 1'b0;
                    r_gnt1 <= 1'b0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign m0_gnt     = r_gnt0;
    assign m1_gnt     = r_gnt1;
    assign m0_done    = r_done0;
    assign m1_done    = r_done1;
    assign m0_rdata   = r_rdata0;
    assign m1_rdata   = r_rdata1;
    assign m0_err     = r_err0;
    assign m1_err     = r_err1;
    assign iobus_addr = r_addr;
    assign iobus_out  = r_wdata;
    assign iobus_wr   = r_strb_wr;
    assign iobus_rd   = r_strb_rd;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iobus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iobus_arbiter
//  Description : Directed self-checking bench for iobus_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iobus_arbiter;
    import iobus_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        RST_N;
    logic        m0_req, m1_req, m0_wr, m1_wr;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] iobus_addr, iobus_out, iobus_in;
    logic        iobus_wr, iobus_rd, iobus_ack, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_k;      // ACCESS cycle carrying the ack; 0 = never
        logic [31:0] rdin;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;    // cycles from request to done
    } vec_t;

    vec_t vecs[6];

    iobus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA_DEFAULT)) dut (
        .clk(clk), .RST_N(RST_N),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .iobus_addr(iobus_addr), .iobus_out(iobus_out), .iobus_wr(iobus_wr),
        .iobus_rd(iobus_rd), .iobus_in(iobus_in), .iobus_ack(iobus_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int          strobes;
        int          acc;
        int          lat;
        int          stray;
        bit          seen;
        bit          first;
        logic [31:0] a_addr, a_out, d_rdata;
        logic        a_wr, a_rd, d_err;
        strobes = 0; acc = 0; lat = 0; stray = 0; seen = 0; first = 1;
        a_addr = 0; a_out = 0; a_wr = 0; a_rd = 0; d_rdata = 0; d_err = 0;
        if (v.port) begin
            m1_req = 1; m1_addr = v.addr; m1_wdata = v.wdata; m1_wr = v.wr;
        end else begin
            m0_req = 1; m0_addr = v.addr; m0_wdata = v.wdata; m0_wr = v.wr;
        end
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            iobus_ack = 1'b0;
            if (iobus_wr || iobus_rd) begin
                strobes++;
                acc++;
                if (first) begin
                    a_addr = iobus_addr; a_out = iobus_out;
                    a_wr = iobus_wr; a_rd = iobus_rd; first = 0;
                end
                if (acc == v.ack_k) begin
                    iobus_ack = 1'b1;
                    iobus_in  = v.rdin;
                end
            end
            if (v.port ? (m0_gnt || m0_done) : (m1_gnt || m1_done)) stray++;
            if (v.port ? m1_done : m0_done) begin
                seen    = 1;
                lat     = c;
                d_rdata = v.port ? m1_rdata : m0_rdata;
                d_err   = v.port ? m1_err : m0_err;
                m0_req  = 0;
                m1_req  = 0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL v%0d_done_timeout actual=none required=done", idx);
            m0_req = 0;
            m1_req = 0;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d_strobe_cycles", idx), 32'(strobes), 32'(v.exp_lat - 1));
        chk($sformatf("v%0d_rdata", idx), d_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), 32'(d_err), 32'(v.exp_err));
        chk($sformatf("v%0d_addr", idx), a_addr, v.addr);
        chk($sformatf("v%0d_wdata", idx), a_out, v.wdata);
        chk($sformatf("v%0d_strobe_kind", idx), {30'b0, a_wr, a_rd}, {30'b0, v.wr, ~v.wr});
        chk($sformatf("v%0d_other_port_quiet", idx), 32'(stray), 32'd0);
        tick();
        chk($sformatf("v%0d_idle_after", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        int dn;
        int overlap;
        int quiet;
        int order[4];
        int when[4];

        RST_N = 0;
        m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        iobus_in = 0; iobus_ack = 0;

        vecs[0] = '{1'b0, 1'b1, ADDR_LEDS,     32'h0000_00A5, 1,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b0, ADDR_SWITCHES, 32'h0000_0000, 3,  32'h0000_1234, 32'h0000_1234, 1'b0, 4};
        vecs[2] = '{1'b0, 1'b0, ADDR_SWITCHES, 32'h0000_0011, 0,  32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 17};
        vecs[3] = '{1'b0, 1'b0, ADDR_BUTTONS,  32'h0000_0022, 16, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 17};
        vecs[4] = '{1'b1, 1'b1, ADDR_COUNT,    32'h0000_0077, 0,  32'h5555_5555, 32'h0000_0000, 1'b1, 17};
        vecs[5] = '{1'b1, 1'b0, ADDR_BUTTONS,  32'h0000_0033, 2,  32'h0000_000F, 32'h0000_000F, 1'b0, 3};

        #2;
        chk("rst_iobus_addr", iobus_addr, 32'h0);
        chk("rst_iobus_out", iobus_out, 32'h0);
        chk("rst_ctrl_bits", {23'b0, iobus_wr, iobus_rd, m0_gnt, m1_gnt, m0_done, m1_done,
                              m0_err, m1_err, busy}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);

        repeat (2) @(posedge clk);
        #3 RST_N = 1;
        tick();

        foreach (vecs[i]) run_txn(i, vecs[i]);
        chk("m0_rdata_held", m0_rdata, 32'hCAFE_0001);

        // Both ports request continuously; the last owner was port 1.
        m0_req = 1; m0_addr = ADDR_LEDS; m0_wdata = 32'h1; m0_wr = 1;
        m1_req = 1; m1_addr = ADDR_SWITCHES; m1_wdata = 32'h2; m1_wr = 0;
        iobus_in = 32'h0000_0ABC;
        dn = 0; overlap = 0;
        for (int i = 0; i < 4; i++) begin order[i] = -1; when[i] = 0; end
        for (int c = 1; c <= 40 && dn < 4; c++) begin
            tick();
            iobus_ack = iobus_wr | iobus_rd;
            if (m0_gnt && m1_gnt) overlap++;
            if (iobus_wr && iobus_rd) overlap++;
            if (m0_done && dn < 4) begin order[dn] = 0; when[dn] = c; dn++; end
            if (m1_done && dn < 4) begin order[dn] = 1; when[dn] = c; dn++; end
        end
        m0_req = 0; m1_req = 0; iobus_ack = 0;
        chk("rr_done_count", 32'(dn), 32'd4);
        chk("rr_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]}, 32'h00010001);
        chk("rr_spacing", {when[1][7:0] - when[0][7:0], when[2][7:0] - when[1][7:0],
                           when[3][7:0] - when[2][7:0], 8'd0}, 32'h03030300);
        chk("rr_overlap", 32'(overlap), 32'd0);
        tick();

        // Reset asserted in the second ACCESS cycle of a port 1 write.
        m1_req = 1; m1_addr = ADDR_LEDS; m1_wdata = 32'h55; m1_wr = 1;
        tick();
        chk("rst_mid_first_access", {30'b0, iobus_wr, m1_gnt}, 32'h3);
        tick();
        RST_N = 0;
        #1;
        chk("rst_mid_strobes_drop", {28'b0, iobus_wr, iobus_rd, m1_gnt, busy}, 32'h0);
        m1_req = 0;
        #1 RST_N = 1;
        quiet = 0;
        iobus_ack = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (m0_done || m1_done || busy) quiet++;
        end
        iobus_ack = 0;
        chk("rst_no_done_and_ack_in_idle_ignored", 32'(quiet), 32'd0);

        m0_req = 1; m0_addr = ADDR_BUTTONS; m0_wr = 0;
        m1_req = 1; m1_addr = ADDR_COUNT; m1_wr = 1;
        iobus_in = 32'h0000_0042;
        tick();
        chk("post_rst_tie_grant", {30'b0, m0_gnt, m1_gnt}, 32'h2);
        iobus_ack = 1;
        tick();
        iobus_ack = 0;
        m0_req = 0; m1_req = 0;
        chk("post_rst_done", {30'b0, m0_done, m1_done}, 32'h2);
        chk("post_rst_rdata", m0_rdata, 32'h0000_0042);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iobus_arbiter.md
# iobus_arbiter

Shares the single OTTER I/O bus between two requesters: port 0 is the MCU-side bus master and port 1 is a debug/host bridge. Round-robin arbitration, one outstanding transaction at a time, and a per-access peripheral ack with timeout. Sits between the requesters and the wrapper's I/O address decode, which drives the LED, count and switch/button ports.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles in ACCESS without `iobus_ack` before the arbiter aborts with an error. Legal range 2..255.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on a timed-out access.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state on the rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `m0_req`, `m1_req`, in, 1: transaction request; held high until that port's `done`.
- `m0_addr`, `m1_addr`, in, 32: I/O address.
- `m0_wdata`, `m1_wdata`, in, 32: write data.
- `m0_wr`, `m1_wr`, in, 1: 1 = write, 0 = read.
- `m0_gnt`, `m1_gnt`, out, 1: high while that port owns the bus (ACCESS and RESP).
- `m0_done`, `m1_done`, out, 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`, out, 32: read result; valid when `done` is high, held until the next `done` on that port.
- `m0_err`, `m1_err`, out, 1: valid with `done`; 1 = timeout.
- `iobus_addr`, out, 32: registered bus address.
- `iobus_out`, out, 32: registered bus write data.
- `iobus_wr`, out, 1: write strobe, high throughout ACCESS for writes.
- `iobus_rd`, out, 1: read strobe, high throughout ACCESS for reads.
- `iobus_in`, in, 32: peripheral read data, sampled on the ack cycle.
- `iobus_ack`, in, 1: peripheral completion.
- `busy`, out, 1: state is not IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE:**
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requests, grant the port that is not `last`. `last` is a 1-bit pointer to the most recently granted port; its reset value is 1, so port 0 wins the first tie.
  - On grant: latch addr/wdata/wr into the bus registers, set `owner`, go to ACCESS.
- **ACCESS:**
  - `iobus_wr`/`iobus_rd` are driven from the latched wr bit; the timeout counter increments each cycle.
  - On `iobus_ack`: capture `iobus_in` into the owner's rdata (writes capture 0), err = 0, go to RESP.
  - When the counter reaches `TIMEOUT-1` without ack: rdata = `ERR_DATA` on reads (0 on writes), err = 1, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- **RESP:**
  - Owner's `done` = 1, strobes low, `last` ← `owner`, go to IDLE.
  - The counter clears on every IDLE entry.
- Requesters are not ordered. Deasserting `req` during ACCESS/RESP does not abort; the transaction completes and `done` still pulses.
- `req` still high in the IDLE cycle after `done` is a new request.
- `iobus_ack` in IDLE or RESP is ignored.
- `iobus_addr`/`iobus_out` hold their last values in IDLE and RESP; only the strobes are qualified by state.

## Timing
- Reset, asynchronous assert: state = IDLE, `last` = 1, all outputs 0 (addr, data, strobes, gnt, done, rdata, err, busy).
- Reset mid-ACCESS drops the strobes immediately and discards the transaction; no `done` follows.
- Zero-wait peripheral (ack in the first ACCESS cycle): req seen at cycle N (IDLE) → strobes at N+1 → `done` at N+2 → IDLE at N+3. Minimum 3 cycles per transaction.
- Peripheral acking after k ACCESS cycles: `done` at N+1+k.
- Timeout: the strobe is high for exactly `TIMEOUT` cycles, then `done` with err = 1.
- Back-to-back with both ports requesting: grants alternate, one transaction per 3 cycles minimum.
- All outputs are registered except `busy`, which is decoded from the state register.

## Structure
- Package `iobus_pkg`:
  - `state_t` enum (IDLE, ACCESS, RESP).
  - `ERR_DATA_DEFAULT`.
  - The I/O port address constants (switches 0x1100_8000, buttons 0x1100_8004, LEDs 0x1100_C000, count 0x1100_C00C), so the bench and the wrapper decode share them.
- One sub-module, `rr_pick2`: combinational 2-way round-robin choice from (req0, req1, last) → (valid, sel). The pointer register lives in the parent.
- Timeout counter width: $clog2(TIMEOUT).

## Test plan
- Reset, then port 0 writes 0x0000_00A5 to 0x1100_C000 with ack on the first ACCESS cycle → `iobus_wr` high 1 cycle, `m0_done` at N+2, `m0_err` = 0, `m0_rdata` = 0.
- Port 1 reads 0x1100_8000, peripheral returns 0x0000_1234 with ack after 3 cycles → `m1_done` at N+4, `m1_rdata` = 0x0000_1234, `m0_gnt` low throughout.
- Both ports request continuously for 4 transactions → grant order 0,1,0,1; strobes never overlap; done pulses 3 cycles apart.
- Port 0 reads with no ack, `TIMEOUT` = 16 → `iobus_rd` high exactly 16 cycles, `m0_err` = 1, `m0_rdata` = 0xDEAD_BEEF. Repeat with ack on cycle 16 → err = 0, data captured.
- `RST_N` pulsed low in the 2nd ACCESS cycle of a port 1 write → strobes drop asynchronously, no `m1_done`. After release, a simultaneous request from both ports grants port 0.
